// File: rtl/filter_out_axis_if.sv
// AXI4-Stream style pixel bus leaving filter_out_axis.
// FILTER_OUT_EOF_EN adds the end-of-frame sideband m_teof.
interface filter_out_axis_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshake: a beat transfers on a rising clock edge where m_tvalid && m_tready.
  // Once m_tvalid is high it stays high, and the payload stays stable, until that transfer.
  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tuser;
  logic                  m_tlast;
`ifdef FILTER_OUT_EOF_EN
  logic                  m_teof;

  modport master (output m_tvalid, m_tdata, m_tuser, m_tlast, m_teof, input m_tready);
  modport slave  (input m_tvalid, m_tdata, m_tuser, m_tlast, m_teof, output m_tready);
`else
  modport master (output m_tvalid, m_tdata, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tvalid, m_tdata, m_tuser, m_tlast, output m_tready);
`endif
endinterface

// File: rtl/filter_out_axis.sv
// Frames the unstallable 3x3 filter pixel stream with SOF/EOL tags and buffers it for an AXI-Stream sink.
// Optional macro FILTER_OUT_EOF_EN adds an end-of-frame tag (m_teof) to each FIFO entry.
module filter_out_axis #(
  parameter int FRAME_H    = 480,
  parameter int FRAME_W    = 640,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          din_vld,
  input  logic [DATA_WIDTH-1:0]         din,
  filter_out_axis_if.master             m_axis,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef FILTER_OUT_EOF_EN
  localparam int TAG_W = 3;
`else
  localparam int TAG_W = 2;
`endif
  localparam int ENT_W = TAG_W + DATA_WIDTH;

  logic [COL_W-1:0] r_col, w_cur_col, w_nxt_col;
  logic [ROW_W-1:0] r_row, w_cur_row, w_nxt_row;
  logic             w_sof, w_eol, w_last_row;
`ifdef FILTER_OUT_EOF_EN
  logic             w_eof;
`endif

  logic [ENT_W-1:0] w_entry, w_rd_entry, r_out_entry;
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level, r_mem_cnt;
  logic             r_out_vld, r_overflow;
  logic             w_pop, w_push, w_load, w_bypass, w_mem_wr, w_mem_rd;

  // frame_start overrides the stored position for this cycle's pixel.
  always_comb begin
    w_cur_col = frame_start ? '0 : r_col;
    w_cur_row = frame_start ? '0 : r_row;
  end

  assign w_sof      = (w_cur_row == '0) && (w_cur_col == '0);
  assign w_eol      = (w_cur_col == COL_W'(FRAME_W - 1));
  assign w_last_row = (w_cur_row == ROW_W'(FRAME_H - 1));

  always_comb begin
    w_nxt_col = w_cur_col;
    w_nxt_row = w_cur_row;
    if (din_vld) begin
      if (w_eol) begin
        w_nxt_col = '0;
        w_nxt_row = w_last_row ? '0 : w_cur_row + ROW_W'(1);
      end else begin
        w_nxt_col = w_cur_col + COL_W'(1);
      end
    end
  end

`ifdef FILTER_OUT_EOF_EN
  assign w_eof   = w_eol && w_last_row;
  assign w_entry = {w_eof, w_sof, w_eol, din};
`else
  assign w_entry = {w_sof, w_eol, din};
`endif

  // The level covers the output register too, so a full FIFO can still accept
  // a pixel in a cycle where the output beat leaves.
  assign w_pop      = r_out_vld && m_axis.m_tready;
  assign w_push     = din_vld && ((r_level < LVL_W'(FIFO_DEPTH)) || w_pop);
  assign w_load     = !r_out_vld || w_pop;
  assign w_mem_rd   = w_load && (r_mem_cnt != '0);
  assign w_bypass   = w_push && w_load && (r_mem_cnt == '0);
  assign w_mem_wr   = w_push && !w_bypass;
  assign w_rd_entry = r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_mem_wr) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_cnt   <= '0;
      r_level     <= '0;
      r_out_vld   <= 1'b0;
      r_out_entry <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_col <= w_nxt_col;
      r_row <= w_nxt_row;

      if (w_mem_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_mem_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end

      case ({w_mem_wr, w_mem_rd})
        2'b10:   r_mem_cnt <= r_mem_cnt + LVL_W'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - LVL_W'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase

      // Output stage refills from storage first; an empty store lets the new pixel fall through.
      if (w_load) begin
        if (w_mem_rd) begin
          r_out_vld   <= 1'b1;
          r_out_entry <= w_rd_entry;
        end else if (w_bypass) begin
          r_out_vld   <= 1'b1;
          r_out_entry <= w_entry;
        end else begin
          r_out_vld   <= 1'b0;
        end
      end

      if (din_vld && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_axis.m_tvalid = r_out_vld;
  assign m_axis.m_tdata  = r_out_entry[DATA_WIDTH-1:0];
  assign m_axis.m_tlast  = r_out_entry[DATA_WIDTH];
  assign m_axis.m_tuser  = r_out_entry[DATA_WIDTH+1];
`ifdef FILTER_OUT_EOF_EN
  assign m_axis.m_teof   = r_out_entry[DATA_WIDTH+2];
`endif
  assign overflow   = r_overflow;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_filter_out_axis.sv
// Self-checking bench for filter_out_axis: queue-based reference model, per-cycle compare, directed scenarios.
module tb_filter_out_axis;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clock;
  logic          rst_n;
  logic          frame_start;
  logic          din_vld;
  logic [DW-1:0] din;
  logic          overflow;
  logic [2:0]    fifo_level;

  filter_out_axis_if #(.DATA_WIDTH(DW)) axis ();

  filter_out_axis #(
    .FRAME_H(H), .FRAME_W(W), .DATA_WIDTH(DW), .FIFO_DEPTH(D)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .din_vld(din_vld),
    .din(din),
    .m_axis(axis),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry layout {eof, sof, eol, data}; the queue holds everything the DUT holds, head = output beat.
  logic [DW+2:0] exp_q[$];
  int            pos_m;
  logic          ov_m;
  int            p_m;
  logic          pop_m, push_m;
  logic [DW+2:0] ent_m;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      pos_m = 0;
      ov_m  = 1'b0;
    end else begin
      p_m    = frame_start ? 0 : pos_m;
      pop_m  = (exp_q.size() > 0) && axis.m_tready;
      push_m = din_vld && ((exp_q.size() < D) || pop_m);
      ent_m  = {(p_m == W*H-1), (p_m == 0), ((p_m % W) == W-1), din};
      pos_m  = din_vld ? (p_m + 1) % (W*H) : p_m;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(ent_m);
      else if (din_vld) ov_m = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  logic [DW+2:0] beat_q[$];
  logic [DW+2:0] got_ent, prev_ent;
  logic          prev_stall;

  always @(negedge clock) begin
`ifdef FILTER_OUT_EOF_EN
    got_ent = {axis.m_teof, axis.m_tuser, axis.m_tlast, axis.m_tdata};
`else
    got_ent = {1'b0, axis.m_tuser, axis.m_tlast, axis.m_tdata};
`endif
    check("tvalid", axis.m_tvalid, exp_q.size() > 0);
    check("fifo_level", fifo_level, exp_q.size());
    check("overflow", overflow, ov_m);
    if (exp_q.size() > 0) begin
      check("tdata", axis.m_tdata, exp_q[0][DW-1:0]);
      check("tlast", axis.m_tlast, exp_q[0][DW]);
      check("tuser", axis.m_tuser, exp_q[0][DW+1]);
`ifdef FILTER_OUT_EOF_EN
      check("teof", axis.m_teof, exp_q[0][DW+2]);
`endif
    end
    if (rst_n && prev_stall) begin
      check("stall_tvalid_hold", axis.m_tvalid, 1'b1);
      check("stall_payload_hold", got_ent, prev_ent);
    end
    prev_stall = rst_n && axis.m_tvalid && !axis.m_tready;
    prev_ent   = got_ent;
    if (rst_n && axis.m_tvalid && axis.m_tready) beat_q.push_back(got_ent);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic fs, input logic r);
    din_vld       = v;
    din           = d;
    frame_start   = fs;
    axis.m_tready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int            n_pix;
  logic [DW+2:0] b;

  initial begin
    prev_stall    = 1'b0;
    prev_ent      = '0;
    rst_n         = 1'b0;
    din_vld       = 1'b0;
    din           = '0;
    frame_start   = 1'b0;
    axis.m_tready = 1'b0;
    idle(2, 1'b0);
    check("rst_tvalid", axis.m_tvalid, 1'b0);
    check("rst_tdata", axis.m_tdata, 8'd0);
    check("rst_tuser", axis.m_tuser, 1'b0);
    check("rst_tlast", axis.m_tlast, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Basic streaming
    beat_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b1);
      if (i == 0) begin
        check("latency_tvalid", axis.m_tvalid, 1'b1);
        check("latency_tdata", axis.m_tdata, 8'd0);
      end
    end
    idle(3, 1'b1);
    check("basic_beats", beat_q.size(), 8);
    for (int i = 0; i < beat_q.size() && i < 8; i++) begin
      b = beat_q[i];
      check("basic_data", b[DW-1:0], i);
      check("basic_tlast", b[DW], (i == 3 || i == 7));
      check("basic_tuser", b[DW+1], (i == 0));
    end
    check("basic_level", fifo_level, 3'd0);
    check("basic_overflow", overflow, 1'b0);

    // Overflow
    beat_q.delete();
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    idle(6, 1'b1);
    drive(1'b1, 8'd9, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("ovf_beats", beat_q.size(), 5);
    if (beat_q.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        b = beat_q[i];
        check("ovf_data", b[DW-1:0], i);
        check("ovf_tlast", b[DW], (i == 3));
      end
      b = beat_q[4];
      check("ovf_after_data", b[DW-1:0], 8'd9);
      check("ovf_after_tuser", b[DW+1], 1'b0);
      check("ovf_after_tlast", b[DW], 1'b0);
    end
    check("ovf_sticky", overflow, 1'b1);

    // Full with concurrent pop
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    check("full_level", fifo_level, 3'd4);
    drive(1'b1, 8'd5, 1'b0, 1'b1);
    check("full_pop_level", fifo_level, 3'd4);
    check("full_pop_overflow", overflow, 1'b0);
    idle(6, 1'b1);

    // Resync
    do_reset();
    beat_q.delete();
    for (int i = 10; i <= 17; i++) drive(1'b1, DW'(i), (i == 13), 1'b1);
    idle(3, 1'b1);
    check("resync_beats", beat_q.size(), 8);
    if (beat_q.size() == 8) begin
      b = beat_q[0]; check("resync_first_tuser", b[DW+1], 1'b1);
      b = beat_q[2]; check("resync_12_tlast", b[DW], 1'b0);
      b = beat_q[3]; check("resync_13_data", b[DW-1:0], 8'd13);
                     check("resync_13_tuser", b[DW+1], 1'b1);
      b = beat_q[6]; check("resync_16_tlast", b[DW], 1'b1);
    end

    // Reset mid-operation
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(20 + i), 1'b0, 1'b0);
    check("mid_level", fifo_level, 3'd3);
    check("mid_tvalid", axis.m_tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", axis.m_tvalid, 1'b0);
    check("mid_rst_tdata", axis.m_tdata, 8'd0);
    check("mid_rst_tuser", axis.m_tuser, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    idle(1, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);
    beat_q.delete();
    drive(1'b1, 8'd42, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("mid_after_beats", beat_q.size(), 1);
    if (beat_q.size() == 1) begin
      b = beat_q[0];
      check("mid_after_data", b[DW-1:0], 8'd42);
      check("mid_after_tuser", b[DW+1], 1'b1);
    end

    // Random backpressure
    do_reset();
    beat_q.delete();
    n_pix = 0;
    while (n_pix < 64) begin
      if ($urandom_range(0, 3) != 0) begin
        drive(1'b1, DW'(n_pix), 1'b0, 1'($urandom_range(0, 1)));
        n_pix++;
      end else begin
        drive(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
    idle(8, 1'b1);
    check("rand_level", fifo_level, 3'd0);
    foreach (beat_q[i]) begin
      b = beat_q[i];
      check("rand_tuser", b[DW+1], (b[DW-1:0] % 8) == 0);
      check("rand_tlast", b[DW], (b[DW-1:0] % 4) == 3);
`ifdef FILTER_OUT_EOF_EN
      check("rand_teof", b[DW+2], (b[DW-1:0] % 8) == 7);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
